demux_frame_router: RTL
=======================

// Module: demux_frame_router
// PURPOSE
//  Serial frame parser that feeds the 1:8 demux (demux1to8) stage. It consumes
//  a bit-serial stream with a valid/ready handshake and decodes a 3-bit channel
//  address. It then drives sel/d so each payload bit appears on the addressed
//  demux output. Sits between the serial link front-end and the demux.
// PARAMETERS
//  DATA_LEN  8  payload bits per frame (>=1), MSB first
//  SEL_W     3  address/select width (fixed 3 for the 1:8 demux)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  in_valid     in   1      upstream bit valid
//  in_bit       in   1      upstream serial bit
//  in_ready     out  1      router can accept a bit (registered)
//  stall        in   1      downstream backpressure; pauses acceptance
//  sel          out  SEL_W  demux select, held for whole payload
//  d            out  1      demux data bit; 0 whenever d_valid=0
//  d_valid      out  1      d/sel carry a payload bit this cycle
//  frame_done   out  1      1-cycle pulse at end of each frame
//  frame_err    out  1      1-cycle pulse with frame_done on parity fail
// BEHAVIOUR
//  Handshake: bit accepted on a rising edge where in_valid && in_ready.
//  in_ready: register; next value = ~stall (1-cycle stall-to-ready latency).
//  Reset (async, immediate): state=IDLE, counters=0; in_ready=0, sel=0, d=0,
//   d_valid=0, frame_done=0, frame_err=0. in_ready rises 1st edge after release
//   if stall=0.
//  FSM states: IDLE, ADDR, DATA, PAR (PAR only with parity enabled).
//   IDLE: accepted 0 bits ignored (line idle); accepted 1 = start -> ADDR, cnt=0.
//   ADDR: shift 3 accepted bits MSB first; on 3rd: sel <= addr, -> DATA, cnt=0.
//   DATA: each accepted bit: d <= bit, d_valid <= 1 for one cycle (1-cycle
//    latency from acceptance). On DATA_LEN-th bit -> PAR, or IDLE with
//    frame_done=1 in the same cycle as the last d_valid.
//   PAR: accepted bit; frame_done=1 next cycle; frame_err=1 if XOR of
//    addr, payload and parity bit != 0 (even parity). -> IDLE.
//  Cycles with no accepted bit: d=0, d_valid=0; FSM/counters hold.
//  in_valid gaps or stall mid-frame: FSM waits indefinitely, no timeout.
//  sel: updates only on address completion; holds across frames until next
//   address; sel never changes while d_valid=1.
//  All 8 addresses (0..7) are legal; there is no address error.
//  Start bit accepted in IDLE in the cycle after frame_done: back-to-back
//   frames with no idle bit are supported.
//  Reset mid-frame: frame discarded, no frame_done, outputs to reset values.
//  Counter: ceil(log2(DATA_LEN+1)) bits; no wrap inside a frame.
// CONFIGURATION
//  DEMUX_ROUTER_PARITY_EN defined: PAR state present; frame = 1 start + 3 addr
//   + DATA_LEN data + 1 parity bit; frame_err is functional.
//  Not defined: no PAR state; frame = 1 + 3 + DATA_LEN bits; frame_err tied 0;
//   frame_done fires with the last d_valid.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs 0 immediately; in_ready=1
//    one edge after release.
//  2 Stream 0,0,1,1,0,1 then A5 MSB first (no parity) -> sel=3'b101 after
//    the 6th bit; d_valid x8 with d=1,0,1,0,0,1,0,1; frame_done with the 8th.
//  3 Same frame, in_valid dropped 3 cycles between data bits 4 and 5 -> no
//    d_valid in gap; payload still 1,0,1,0,0,1,0,1; sel stays 5.
//  4 stall=1 for 2 cycles mid-payload -> in_ready=0 one cycle later;
//    no bits lost or duplicated; 8 d_valid pulses total.
//  5 PARITY_EN: addr 010, data 8'h01, parity 0 -> frame_done, frame_err=0;
//    parity 1 -> frame_done and frame_err=1.
//  6 Reset after addr 111 + 3 data bits -> no frame_done; next frame with
//    addr 000 gives sel=0 and a full 8-bit payload.

Source files
------------

// File: rtl/demux_frame_router.sv
// demux_frame_router: bit-serial frame parser feeding a 1:8 demux.
// Frame: start bit (1), SEL_W address bits MSB first, DATA_LEN payload bits
// MSB first, plus one even-parity bit when DEMUX_ROUTER_PARITY_EN is defined.
// Each accepted payload bit is presented on d with d_valid one cycle after
// acceptance, while sel holds the decoded address.
// Optional feature macro: DEMUX_ROUTER_PARITY_EN (parity bit and frame_err).
module demux_frame_router #(
  parameter int DATA_LEN = 8,
  parameter int SEL_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic             stall,
  output logic [SEL_W-1:0] sel,
  output logic             d,
  output logic             d_valid,
  output logic             frame_done,
  output logic             frame_err
);

  localparam int CNT_W  = $clog2(DATA_LEN + 1);
  localparam int ACNT_W = $clog2(SEL_W);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    PAR
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ACNT_W-1:0]  addr_cnt;
  logic [SEL_W-2:0]   addr_sh;
`ifdef DEMUX_ROUTER_PARITY_EN
  logic               par_acc;
`endif

  logic accept;
  assign accept = in_valid && in_ready;

  // Frame FSM with registered handshake, select and demux outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, regardless of statement order in this block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_cnt   <= '0;
      addr_sh    <= '0;
`ifdef DEMUX_ROUTER_PARITY_EN
      par_acc    <= 1'b0;
`endif
      in_ready   <= 1'b0;
      sel        <= '0;
      d          <= 1'b0;
      d_valid    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      in_ready <= ~stall;
      // NOTE: pulse outputs default low every cycle; the accepting branch
      // below overrides them for exactly the cycle after acceptance.
      d          <= 1'b0;
      d_valid    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            // A 0 on an idle line is filler; a 1 marks the start of a frame.
            if (in_bit) begin
              state    <= ADDR;
              cnt      <= '0;
              addr_cnt <= '0;
`ifdef DEMUX_ROUTER_PARITY_EN
              par_acc  <= 1'b0;
`endif
            end
          end
          ADDR: begin
            addr_sh  <= {addr_sh[SEL_W-3:0], in_bit};
            addr_cnt <= addr_cnt + 1'b1;
`ifdef DEMUX_ROUTER_PARITY_EN
            par_acc  <= par_acc ^ in_bit;
`endif
            if (addr_cnt == ACNT_W'(SEL_W - 1)) begin
              sel   <= {addr_sh, in_bit};
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            d       <= in_bit;
            d_valid <= 1'b1;
            cnt     <= cnt + 1'b1;
`ifdef DEMUX_ROUTER_PARITY_EN
            par_acc <= par_acc ^ in_bit;
            if (cnt == CNT_W'(DATA_LEN - 1)) begin
              state <= PAR;
            end
`else
            if (cnt == CNT_W'(DATA_LEN - 1)) begin
              state      <= IDLE;
              frame_done <= 1'b1;
            end
`endif
          end
`ifdef DEMUX_ROUTER_PARITY_EN
          PAR: begin
            // Even parity over address, payload and the parity bit itself.
            frame_done <= 1'b1;
            frame_err  <= par_acc ^ in_bit;
            state      <= IDLE;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
